// File: rtl/irq_collector.sv
// irq_collector: device interrupt front end feeding the coprocessor cause logic.
// Each of lines 1..30 goes through a two-flop synchroniser and a run-length glitch
// filter. Rising-edge detection follows the filter. The block emits registered
// one-cycle cause pulses on ir_map. Level-type lines are re-pulsed on every
// repeat tick while they remain asserted.
module irq_collector #(
    parameter logic [30:1] EDGE_MASK    = 30'h0,
    parameter int          FILTER_LEN   = 4,
    parameter int          LEVEL_REPEAT = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [30:1] irq_in,
    input  logic [30:1] irq_mask,
    output logic [30:1] ir_map,
    output logic [30:1] irq_level,
    output logic        tick
);

    localparam int              CNT_W    = $clog2(FILTER_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    // Synchroniser stages: p0 is the metastability catcher, p1 feeds the filter.
    logic [30:1]      r_sync_p0;
    logic [30:1]      r_sync_p1;

    // Filter state. r_level is the accepted level, r_level_q is its previous value
    // and serves as edge history.
    logic [CNT_W-1:0] r_cnt [1:30];
    logic [30:1]      r_level;
    logic [30:1]      r_level_q;

    logic [CNT_W-1:0] w_cnt_nxt [1:30];
    logic [30:1]      w_level_nxt;
    logic [30:1]      w_rise;
    logic [30:1]      w_map_nxt;

    logic [30:1]      r_map;
    logic             r_tick;

    // Two-flop synchroniser. Nothing other than p1 reads p0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_sync_p0 <= irq_in;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Glitch filter: accept a new level once it has differed from the accepted level for FILTER_LEN cycles in a row.
    always_comb begin
        w_level_nxt = r_level;
        for (int i = 1; i <= 30; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (r_sync_p1[i] == r_level[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_LAST) begin
                w_level_nxt[i] = r_sync_p1[i];
                w_cnt_nxt[i]   = '0;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    // Filter registers and level history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= 30; i++) begin
                r_cnt[i] <= '0;
            end
            r_level   <= '0;
            r_level_q <= '0;
        end else begin
            for (int i = 1; i <= 30; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_level   <= w_level_nxt;
            r_level_q <= r_level;
        end
    end

    // The cause pulse is the accepted rising edge, or a level line seen on a tick.
    // The mask gates the pulse that is being computed in the current cycle.
    always_comb begin
        w_rise    = r_level & ~r_level_q;
        w_map_nxt = irq_mask & (w_rise | (~EDGE_MASK & {30{r_tick}} & r_level));
    end

    // Registered cause pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_map <= '0;
        end else begin
            r_map <= w_map_nxt;
        end
    end

    generate
        if (LEVEL_REPEAT > 0) begin : g_repeat
            localparam int           RW    = (LEVEL_REPEAT > 1) ? $clog2(LEVEL_REPEAT) : 1;
            localparam logic [RW-1:0] RLAST = RW'(LEVEL_REPEAT - 1);
            logic [RW-1:0] r_rcnt;

            // Free-running repeat counter; tick follows each wrap by one cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rcnt <= '0;
                    r_tick <= 1'b0;
                end else begin
                    r_tick <= (r_rcnt == RLAST);
                    r_rcnt <= (r_rcnt == RLAST) ? '0 : r_rcnt + RW'(1);
                end
            end
        end else begin : g_no_repeat
            // Re-pulsing is disabled, so the tick stays low.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tick <= 1'b0;
                end else begin
                    r_tick <= 1'b0;
                end
            end
        end
    endgenerate

    assign ir_map    = r_map;
    assign irq_level = r_level;
    assign tick      = r_tick;

endmodule
